// File: rtl/nvm_burst_reader_if.sv
// Bus bundle for nvm_burst_reader: request/control, NVM serial port and
// word-level valid/ready read channel. The reader uses the slave modport;
// the requester / NVM side uses the master modport.
interface nvm_burst_reader_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int BURST_W = 4
);
  logic                read_en;
  logic                abort;
  logic [ADDR_W-1:0]   start_addr;
  logic [BURST_W-1:0]  burst_len;
  logic [ADDR_W-1:0]   nvm_addr;
  logic                load;
  logic                shift;
  logic                serial_in;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                rd_ready;
  logic                rd_perr;
  logic                busy;
  logic                done;

  modport slave (
    input  read_en, abort, start_addr, burst_len, serial_in, rd_ready,
    output nvm_addr, load, shift, rd_data, rd_valid, rd_perr, busy, done
  );

  modport master (
    output read_en, abort, start_addr, burst_len, serial_in, rd_ready,
    input  nvm_addr, load, shift, rd_data, rd_valid, rd_perr, busy, done
  );
endinterface

// File: rtl/nvm_burst_reader.sv
// nvm_burst_reader: reads a burst of consecutive NVM words through the
// serial load/shift port, deserialises each word MSB first and hands it out
// on a valid/ready channel.
// Build option: define NVM_BURST_READER_PARITY_EN to expect one trailing
// even-parity bit per word (SHIFT lasts DATA_W+1 cycles, rd_perr reports a
// mismatch). Without it SHIFT lasts DATA_W cycles and rd_perr stays 0.
module nvm_burst_reader #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  nvm_burst_reader_if.slave  bus
);

`ifdef NVM_BURST_READER_PARITY_EN
  localparam int SHIFT_LEN = DATA_W + 1;
`else
  localparam int SHIFT_LEN = DATA_W;
`endif
  localparam int CNT_W = $clog2(SHIFT_LEN + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SHIFT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   nvm_addr_q;
  logic [BURST_W-1:0]  wcnt_q;
  logic [CNT_W-1:0]    bcnt_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                load_q;
  logic                shift_q;
  logic                rd_valid_q;
  logic                rd_perr_q;
  logic                done_q;
  logic                busy_q;

`ifdef NVM_BURST_READER_PARITY_EN
  // Even parity over the deserialised data bits.
  function automatic logic word_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  // Burst sequencer: state, counters, shift register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      nvm_addr_q <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      rd_data_q  <= '0;
      load_q     <= 1'b0;
      shift_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_perr_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (bus.abort && (state_q != IDLE)) begin
      // Abort wins over everything, including a handshake in HOLD; no done.
      state_q    <= IDLE;
      load_q     <= 1'b0;
      shift_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_perr_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.read_en && !bus.abort) begin
            nvm_addr_q <= bus.start_addr;
            wcnt_q     <= bus.burst_len;
            load_q     <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          load_q  <= 1'b0;
          shift_q <= 1'b1;
          bcnt_q  <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          bcnt_q <= bcnt_q + CNT_W'(1);
`ifdef NVM_BURST_READER_PARITY_EN
          // The final shift cycle carries the parity bit, kept out of rd_data.
          if (bcnt_q != BIT_LAST)
            rd_data_q <= {rd_data_q[DATA_W-2:0], bus.serial_in};
`else
          rd_data_q <= {rd_data_q[DATA_W-2:0], bus.serial_in};
`endif
          if (bcnt_q == BIT_LAST) begin
            shift_q    <= 1'b0;
            rd_valid_q <= 1'b1;
            state_q    <= HOLD;
`ifdef NVM_BURST_READER_PARITY_EN
            rd_perr_q  <= word_parity(rd_data_q) ^ bus.serial_in;
`endif
          end
        end
        HOLD: begin
          if (rd_valid_q && bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            rd_perr_q  <= 1'b0;
            if (wcnt_q == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              wcnt_q     <= wcnt_q - BURST_W'(1);
              nvm_addr_q <= nvm_addr_q + ADDR_W'(1);
              load_q     <= 1'b1;
              state_q    <= LOAD;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          load_q     <= 1'b0;
          shift_q    <= 1'b0;
          rd_valid_q <= 1'b0;
          rd_perr_q  <= 1'b0;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.nvm_addr = nvm_addr_q;
  assign bus.load     = load_q;
  assign bus.shift    = shift_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_perr  = rd_perr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
